compare_seq: RTL and testbench

//   Multi-cycle, parametrised magnitude comparator: successor of the 1-bit Equal/Alarger/Blarger cell.

---
 rtl/compare_seq.sv | 110 +++++++++++
 tb/tb_compare_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, with Start/Busy/Done handshake and optional early exit.
module compare_seq #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Equal,
    output logic             Alarger,
    output logic             Blarger
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, next_state;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] a_in, b_in;
    logic [CW-1:0]    count;
    logic             found, a_first;
    logic [DIGIT-1:0] da, db;
    logic             diff, finish, accept;

    always_comb begin
        da     = sa[WIDTH-1 -: DIGIT];
        db     = sb[WIDTH-1 -: DIGIT];
        diff   = (da != db);
        finish = (state == SCAN) && ((count == LAST) || ((EARLY_EXIT != 0) && diff));
        accept = Start && ((state == IDLE) || (state == DONE));
        // Offset-binary mapping: flipping both MSBs turns a signed order into an unsigned one.
        a_in = A;
        b_in = B;
        if (Signed) begin
            a_in[WIDTH-1] = ~A[WIDTH-1];
            b_in[WIDTH-1] = ~B[WIDTH-1];
        end
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SCAN : IDLE;
            SCAN:    next_state = finish ? DONE : SCAN;
            DONE:    next_state = accept ? SCAN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Equal   <= 1'b0;
            Alarger <= 1'b0;
            Blarger <= 1'b0;
            sa      <= '0;
            sb      <= '0;
            count   <= '0;
            found   <= 1'b0;
            a_first <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state == SCAN);
            Done  <= (next_state == DONE);
            if (accept) begin
                sa      <= a_in;
                sb      <= b_in;
                count   <= '0;
                found   <= 1'b0;
                a_first <= 1'b0;
            end else if (state == SCAN) begin
                sa    <= sa << DIGIT;
                sb    <= sb << DIGIT;
                count <= finish ? '0 : count + 1'b1;
                if (diff && !found) begin
                    found   <= 1'b1;
                    a_first <= (da > db);
                end
            end
            // The winner may be recorded on an earlier edge or decided by this edge's digit.
            if (finish) begin
                if (found) begin
                    Equal   <= 1'b0;
                    Alarger <= a_first;
                    Blarger <= ~a_first;
                end else if (diff) begin
                    Equal   <= 1'b0;
                    Alarger <= (da > db);
                    Blarger <= (da < db);
                end else begin
                    Equal   <= 1'b1;
                    Alarger <= 1'b0;
                    Blarger <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_seq.sv
// Bench for compare_seq: two instances (EARLY_EXIT 0 and 1, WIDTH=8, DIGIT=2)
// driven in parallel and checked every cycle against an arithmetic reference model.
module tb_compare_seq;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             sg = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       busy, done, eq, agt, bgt;

    int checks = 0;
    int errors = 0;

    int         m_rem  [2];
    logic       m_done [2];
    logic [2:0] m_res  [2];
    logic [2:0] m_pend [2];

    always #5 clk = ~clk;

    compare_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .reset(reset), .Start(start), .Signed(sg), .A(a), .B(b),
        .Busy(busy[0]), .Done(done[0]), .Equal(eq[0]), .Alarger(agt[0]), .Blarger(bgt[0])
    );

    compare_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .reset(reset), .Start(start), .Signed(sg), .A(a), .B(b),
        .Busy(busy[1]), .Done(done[1]), .Equal(eq[1]), .Alarger(agt[1]), .Blarger(bgt[1])
    );

    // Expected {Equal, Alarger, Blarger} straight from integer comparison.
    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        int ix, iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        if (ix == iy) return 3'b100;
        return (ix > iy) ? 3'b010 : 3'b001;
    endfunction

    // 1-based index of the first differing digit (MSB first), or N if equal.
    function automatic int ref_first_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = 0; i < N; i++)
            if (((d >> (WIDTH - DIGIT * (i + 1))) & ((1 << DIGIT) - 1)) != 0) return i + 1;
        return N;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_rem[i]  = 0;
                m_done[i] = 1'b0;
                m_res[i]  = 3'b000;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_done[i] = (m_rem[i] == 0);
                if (m_rem[i] == 0) m_res[i] = m_pend[i];
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    m_rem[i]  = (i == 0) ? N : ref_first_diff(a, b);
                    m_pend[i] = ref_cmp(a, b, sg);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "busy0" : "busy1", 32'(busy[i]), 32'(m_rem[i] > 0));
            check(i == 0 ? "done0" : "done1", 32'(done[i]), 32'(m_done[i]));
            check(i == 0 ? "result0" : "result1", 32'({eq[i], agt[i], bgt[i]}), 32'(m_res[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    // One request, then measure edges to Done on both instances and check against literals.
    task automatic directed(input string name, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                            input logic s, input logic [2:0] exp_res, input int lat0, input int lat1);
        int got0, got1;
        logic [2:0] r0, r1;
        got0 = 0; got1 = 0; r0 = '0; r1 = '0;
        start = 1'b1; a = xa; b = xb; sg = s;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12 && (got0 == 0 || got1 == 0); k++) begin
            step();
            if (done[0] && got0 == 0) begin got0 = k; r0 = {eq[0], agt[0], bgt[0]}; end
            if (done[1] && got1 == 0) begin got1 = k; r1 = {eq[1], agt[1], bgt[1]}; end
        end
        check({name, "_lat0"}, 32'(got0), 32'(lat0));
        check({name, "_lat1"}, 32'(got1), 32'(lat1));
        check({name, "_res0"}, 32'(r0), 32'(exp_res));
        check({name, "_res1"}, 32'(r1), 32'(exp_res));
        step();
    endtask

    initial begin
        int last_done, n_pulses;
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_done[i] = 1'b0; m_res[i] = '0; m_pend[i] = '0;
        end

        // Hand-computed pins on the reference model itself.
        check("pin_cmp_u",  32'(ref_cmp(8'h80, 8'h7F, 1'b0)), 32'(3'b010));
        check("pin_cmp_s",  32'(ref_cmp(8'h80, 8'h7F, 1'b1)), 32'(3'b001));
        check("pin_cmp_eq", 32'(ref_cmp(8'h5A, 8'h5A, 1'b0)), 32'(3'b100));
        check("pin_fd_top", 32'(ref_first_diff(8'h80, 8'h7F)), 32'd1);
        check("pin_fd_low", 32'(ref_first_diff(8'h12, 8'h13)), 32'd4);

        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("reset_outs", 32'({busy, done, eq, agt, bgt}), 32'd0);
        step();

        directed("t1_eq",    8'h5A, 8'h5A, 1'b0, 3'b100, 4, 4);
        directed("t2_uns",   8'h80, 8'h7F, 1'b0, 3'b010, 4, 1);
        directed("t2_sgn",   8'h80, 8'h7F, 1'b1, 3'b001, 4, 1);
        directed("t3_last",  8'h12, 8'h13, 1'b0, 3'b001, 4, 4);

        // Start during SCAN must be ignored.
        start = 1'b1; a = 8'h01; b = 8'h02; sg = 1'b0;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 8'hFF; b = 8'h00;
        step();
        start = 1'b0;
        step(); step();
        check("t4_done0", 32'(done[0]), 32'd1);
        check("t4_res0",  32'({eq[0], agt[0], bgt[0]}), 32'(3'b001));
        step();

        // Reset mid-scan aborts with no Done.
        start = 1'b1; a = 8'hF0; b = 8'h0F;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_cleared", 32'({busy, done, eq, agt, bgt}), 32'd0);
        step();
        check("t5_no_done", 32'(done), 32'd0);
        directed("t5_after", 8'h0F, 8'h0F, 1'b0, 3'b100, 4, 4);

        // Start held high: back-to-back compares with period N+1.
        start = 1'b1;
        last_done = -1; n_pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); sg = 1'($urandom);
            step();
            if (done[0]) begin
                if (last_done >= 0) check("t6_period", 32'(k - last_done), 32'(N + 1));
                last_done = k;
                n_pulses++;
            end
        end
        check("t6_pulses", 32'(n_pulses), 32'd5);
        start = 1'b0;
        step();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(2) == 0);
            sg    = 1'($urandom);
            a     = WIDTH'($urandom);
            b     = ($urandom_range(7) == 0) ? a : WIDTH'($urandom);
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
